// File: rtl/sr_latch_checker.sv
// sr_latch_checker: clocked observer of an SR latch. It tracks the expected state,
// flags S=R=1 drive and Q/Qbar mismatches, and keeps saturating counters and a sticky error.
module sr_latch_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             r_in,
  input  logic             q_in,
  input  logic             qbar_in,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             invalid_pulse,
  output logic             mismatch_pulse,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] reset_cnt,
  output logic [CNT_W-1:0] invalid_cnt,
  output logic             err_sticky
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {UNKNOWN = 2'b00, SET = 2'b01, RESET = 2'b10, INVALID = 2'b11} state_t;
  state_t st, nxt;
  logic [1:0] s_sy, r_sy, q_sy, qb_sy;
  logic ss, rs, qs, qbs, entry, fail, armed;
  logic [SW-1:0] settle;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic hit);
    return (hit && c != '1) ? c + 1'b1 : c;
  endfunction
  assign ss = s_sy[1];
  assign rs = r_sy[1];
  assign qs = q_sy[1];
  assign qbs = qb_sy[1];
  assign state = st;
  assign exp_q = st == SET;
  assign exp_valid = st == SET || st == RESET;
  always_comb begin
    nxt = (ss && rs) ? INVALID : ss ? SET : rs ? RESET : (st == INVALID) ? UNKNOWN : st;
    entry = nxt != st;
    fail = 1'b0;
    if (armed && settle == '0)
      fail = exp_valid ? (qs != exp_q || qbs == exp_q) : (st == INVALID) ? (qs || qbs) : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sy <= '0;
      r_sy <= '0;
      q_sy <= '0;
      qb_sy <= '0;
      st <= UNKNOWN;
      settle <= SW'(SETTLE_CYCLES);
      armed <= 1'b1;
      invalid_pulse <= 1'b0;
      mismatch_pulse <= 1'b0;
      set_cnt <= '0;
      reset_cnt <= '0;
      invalid_cnt <= '0;
      err_sticky <= 1'b0;
    end else begin
      s_sy <= {s_sy[0], s_in};
      r_sy <= {r_sy[0], r_in};
      q_sy <= {q_sy[0], q_in};
      qb_sy <= {qb_sy[0], qbar_in};
      st <= nxt;
      settle <= entry ? SW'(SETTLE_CYCLES) : (settle == '0) ? settle : settle - 1'b1;
      // a failure disarms the check for the rest of the episode; entry re-arms it
      armed <= entry ? 1'b1 : armed && !fail;
      invalid_pulse <= entry && nxt == INVALID;
      mismatch_pulse <= fail;
      set_cnt <= clr ? '0 : bump(set_cnt, entry && nxt == SET);
      reset_cnt <= clr ? '0 : bump(reset_cnt, entry && nxt == RESET);
      invalid_cnt <= clr ? '0 : bump(invalid_cnt, entry && nxt == INVALID);
      err_sticky <= clr ? 1'b0 : err_sticky || fail;
    end
  end
endmodule
